// File: rtl/alu_ops.sv
// Shared ALU definitions: opcode encodings, NZCV flag struct, result-buffer occupancy states.
// Opcode width is fixed at 4 bits; any W-bit datapath using these encodings must have W = 4.
// is_flag_op() identifies the opcodes whose flags update the architectural status register.
package alu_ops;

  localparam int OP_W = 4;
  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t ADD_OP = 4'h0;
  localparam opcode_t SUB_OP = 4'h1;
  localparam opcode_t AND_OP = 4'h2;
  localparam opcode_t OR_OP  = 4'h3;
  localparam opcode_t XOR_OP = 4'h4;
  localparam opcode_t NOT_OP = 4'h5;
  localparam opcode_t SHL_OP = 4'h6;
  localparam opcode_t SHR_OP = 4'h7;

  // Bit order {n,z,c,v}, so the packed value maps directly onto status_nzcv[3:0].
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_t;

  // Only arithmetic ops set the architectural flags. Undefined encodings fall through as non-setting.
  function automatic logic is_flag_op(input opcode_t op);
    return (op == ADD_OP) || (op == SUB_OP);
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, the result stage, and the result consumer.
// Ports: ALU side  in_valid/in_ready, in_opcode, in_y, in_c, in_v, in_n, in_z;
//        consumer side out_valid/out_ready, out_y, out_flags {n,z,c,v}.
interface alu_result_stage_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_opcode;
  logic [W-1:0] in_y;
  logic         in_c;
  logic         in_v;
  logic         in_n;
  logic         in_z;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;
  logic [3:0]   out_flags;

  // The master drives ALU results and consumer ready; the slave is the result stage.
  modport master (
    output in_valid, in_opcode, in_y, in_c, in_v, in_n, in_z, out_ready,
    input  in_ready, out_valid, out_y, out_flags
  );

  modport slave (
    input  in_valid, in_opcode, in_y, in_c, in_v, in_n, in_z, out_ready,
    output in_ready, out_valid, out_y, out_flags
  );
endinterface

// File: rtl/alu_status_reg.sv
// Architectural NZCV status register; clear takes priority over a same-cycle flag update.
// Ports: clk, rst (async active-high), clear_i, upd_i, nzcv_i -> status_o, carry_fb_o.
// status_o is registered, and carry_fb_o is the registered C bit returned to the ALU carry input.
module alu_status_reg
  import alu_ops::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clear_i,
  input  logic  upd_i,
  input  nzcv_t nzcv_i,
  output nzcv_t status_o,
  output logic  carry_fb_o
);

  nzcv_t status_q;
  nzcv_t status_d;

  always_comb begin
    status_d = status_q;
    if (clear_i) begin
      status_d = '0;
    end else if (upd_i) begin
      status_d = nzcv_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  assign status_o   = status_q;
  assign carry_fb_o = status_q.c;

endmodule

// File: rtl/alu_result_stage.sv
// Result/writeback stage: buffers ALU results and flags in a 2-entry FIFO and drives the NZCV status register.
// Ports: clk, rst (async active-high), bus (slave modport), clear_flags -> status_nzcv {N,Z,C,V}, carry_fb.
// Latency is one cycle with no bypass, and in_ready is a registered not-FULL bit independent of out_ready.
module alu_result_stage
  import alu_ops::*;
#(
  parameter int W = 4
) (
  input  logic                clk,
  input  logic                rst,
  alu_result_stage_if.slave   bus,
  input  logic                clear_flags,
  output logic [3:0]          status_nzcv,
  output logic                carry_fb
);

  occ_state_t   state_q;
  occ_state_t   state_d;
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic [W-1:0] y_mem_q    [2];
  nzcv_t        flag_mem_q [2];

  nzcv_t        in_flags;
  nzcv_t        status;
  logic         push;
  logic         pop;
  logic         upd_flags;

  assign in_flags = '{n: bus.in_n, z: bus.in_z, c: bus.in_c, v: bus.in_v};

  // in_ready_q is low in FULL, so a pop in FULL cannot admit a same-cycle push.
  assign push = bus.in_valid & in_ready_q;
  assign pop  = out_valid_q & bus.out_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:  if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Handshake outputs are registered from the next state so that they carry no combinational path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        y_mem_q[i]    <= '0;
        flag_mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      if (push) begin
        y_mem_q[wr_ptr_q]    <= bus.in_y;
        flag_mem_q[wr_ptr_q] <= in_flags;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = y_mem_q[rd_ptr_q];
  assign bus.out_flags = flag_mem_q[rd_ptr_q];

  // Status is committed when an entry is accepted, not when the consumer drains it.
  assign upd_flags = push & is_flag_op(OP_W'(bus.in_opcode));

  alu_status_reg u_status (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear_flags),
    .upd_i      (upd_flags),
    .nzcv_i     (in_flags),
    .status_o   (status),
    .carry_fb_o (carry_fb)
  );

  assign status_nzcv = status;

endmodule
